// File: rtl/uart_hex_pkg.sv
// Shared types and constants for the UART hex dumper.
// Optional macro UART_HEX_CRLF_EN selects a CR/LF terminator instead of a space.
package uart_hex_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMIT  = 3'd1,
    ACK   = 3'd2,
    DRAIN = 3'd3,
    TERM  = 3'd4
  } state_t;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A_M10 = 8'h37;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_SP    = 8'h20;

`ifdef UART_HEX_CRLF_EN
  localparam int unsigned TERM_N = 2;
`else
  localparam int unsigned TERM_N = 1;
`endif

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASC_0 + 8'(n)) : (ASC_A_M10 + 8'(n));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with synchronous active-high reset.
// Ports: i_clk, i_rst, i_push/i_push_data (ignored when full), i_pop (ignored when
// empty), o_pop_data (head word, read from registered storage), o_full, o_empty, o_level.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // Pop is evaluated against the current occupancy, push against the current full flag.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Storage has no reset; only pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_dumper.sv
// Buffers debug words and prints each as uppercase ASCII hex (MSB nibble first) plus a
// terminator, one byte per UART wr/busy handshake.
// Ports: sys_clk_i, sys_rst_i (sync, active high); word_valid_i/word_dat_i/word_ready_o
// word input; uart_busy_i, uart_wr_o, uart_dat_o UART side; fifo_level_o occupancy.
// Macro UART_HEX_CRLF_EN: terminator CR LF when defined, single space otherwise.
module uart_hex_dumper
  import uart_hex_pkg::*;
#(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          word_valid_i,
  input  logic [WORD_W-1:0]             word_dat_i,
  output logic                          word_ready_o,
  input  logic                          uart_busy_i,
  output logic                          uart_wr_o,
  output logic [7:0]                    uart_dat_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned NIB = WORD_W / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_word, w_word_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic              r_in_term, w_in_term_nxt;
  logic              r_term_idx, w_term_idx_nxt;
  logic              r_wr, w_wr_nxt;
  logic [7:0]        r_dat, w_dat_nxt;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [WORD_W-1:0] w_head;
  logic [IW-1:0]     w_idx_dec;
  logic [7:0]        w_term_byte;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (sys_clk_i),
    .i_rst       (sys_rst_i),
    .i_push      (word_valid_i),
    .i_push_data (word_dat_i),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level_o)
  );

  assign word_ready_o = !w_full;
  assign uart_wr_o    = r_wr;
  assign uart_dat_o   = r_dat;
  assign w_idx_dec    = r_idx - IW'(1);

`ifdef UART_HEX_CRLF_EN
  assign w_term_byte = r_term_idx ? ASC_LF : ASC_CR;
`else
  assign w_term_byte = ASC_SP;
`endif

  // State and registered outputs.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_idx      <= '0;
      r_in_term  <= 1'b0;
      r_term_idx <= 1'b0;
      r_wr       <= 1'b0;
      r_dat      <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_idx      <= w_idx_nxt;
      r_in_term  <= w_in_term_nxt;
      r_term_idx <= w_term_idx_nxt;
      r_wr       <= w_wr_nxt;
      r_dat      <= w_dat_nxt;
    end
  end

  // Next state; a wr pulse is scheduled on every entry into EMIT so it is high only there.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_idx_nxt      = r_idx;
    w_in_term_nxt  = r_in_term;
    w_term_idx_nxt = r_term_idx;
    w_wr_nxt       = 1'b0;
    w_dat_nxt      = r_dat;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_word_nxt     = w_head;
          w_idx_nxt      = IW'(NIB - 1);
          w_in_term_nxt  = 1'b0;
          w_term_idx_nxt = 1'b0;
          w_wr_nxt       = 1'b1;
          w_dat_nxt      = hex_ascii(w_head[WORD_W-1 -: 4]);
          w_state_nxt    = EMIT;
        end
      end
      EMIT:  w_state_nxt = ACK;
      // UART busy appears one cycle after the pulse; ACK covers that gap.
      ACK:   w_state_nxt = DRAIN;
      DRAIN: begin
        if (!uart_busy_i) begin
          if (!r_in_term) begin
            if (r_idx != '0) begin
              w_idx_nxt   = w_idx_dec;
              w_wr_nxt    = 1'b1;
              w_dat_nxt   = hex_ascii(r_word[{w_idx_dec, 2'b00} +: 4]);
              w_state_nxt = EMIT;
            end else begin
              w_in_term_nxt  = 1'b1;
              w_term_idx_nxt = 1'b0;
              w_state_nxt    = TERM;
            end
          end else if (r_term_idx != 1'(TERM_N - 1)) begin
            w_term_idx_nxt = r_term_idx + 1'b1;
            w_state_nxt    = TERM;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      TERM: begin
        w_wr_nxt    = 1'b1;
        w_dat_nxt   = w_term_byte;
        w_state_nxt = EMIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_hex_dumper.sv
// Self-checking bench for uart_hex_dumper with a behavioural UART (busy one cycle after wr).
module tb_uart_hex_dumper;

`ifdef UART_HEX_CRLF_EN
  localparam int TN = 2;
`else
  localparam int TN = 1;
`endif
  localparam int NB        = 4 + TN;
  localparam int BUSY_CYC  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        word_valid = 1'b0;
  logic [15:0] word_dat = 16'h0000;
  logic        word_ready;
  logic        uart_busy = 1'b0;
  logic        uart_wr;
  logic [7:0]  uart_dat;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  uart_hex_dumper #(.WORD_W(16), .FIFO_DEPTH(8)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .word_valid_i (word_valid),
    .word_dat_i   (word_dat),
    .word_ready_o (word_ready),
    .uart_busy_i  (uart_busy),
    .uart_wr_o    (uart_wr),
    .uart_dat_o   (uart_dat),
    .fifo_level_o (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART: latches on wr, raises busy on the following edge for BUSY_CYC+1 cycles.
  logic pend = 1'b0;
  int   bcnt = 0;
  always @(posedge clk) begin
    if (pend) begin
      uart_busy <= 1'b1;
      bcnt      <= BUSY_CYC;
      pend      <= 1'b0;
    end else if (uart_busy) begin
      if (bcnt == 0) uart_busy <= 1'b0;
      else           bcnt      <= bcnt - 1;
    end
    if (uart_wr) pend <= 1'b1;
  end

  // Monitor and scoreboard feed, sampled mid-cycle.
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         wr_cyc_q[$];
  int         acc_cyc = 0;
  int         viol = 0;
  int         ready_bad = 0;
  int         max_level = 0;
  logic       prev_wr = 1'b0;
  string      hexs = "0123456789ABCDEF";

  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) begin
        acc_cyc = cyc + 1;
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(hexs[(word_dat >> (4 * i)) & 16'h000F]));
`ifdef UART_HEX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(8'h20);
`endif
      end
      if (uart_wr) begin
        rx_q.push_back(uart_dat);
        wr_cyc_q.push_back(cyc + 1);
        if (uart_busy || prev_wr) viol++;
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (word_ready !== (fifo_level < 4'd8)) ready_bad++;
    end
    prev_wr = uart_wr;
  end

  task automatic clear_sb();
    exp_q.delete();
    rx_q.delete();
    wr_cyc_q.delete();
    viol = 0;
    ready_bad = 0;
    max_level = 0;
  endtask

  task automatic push_word(input logic [15:0] w, output int stalls);
    int k;
    stalls = 0;
    k = 0;
    word_valid = 1'b1;
    word_dat   = w;
    while (word_ready !== 1'b1 && k < 2000) begin
      @(posedge clk); #1;
      k++;
      stalls++;
    end
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: word_ready=%b required 1", word_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (rx_q.size() >= n);
    repeat (40) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    word_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b required 0", uart_wr); end
    checks++; if (uart_dat !== 8'h00) begin errors++; $display("FAIL rst_dat: got %h required 00", uart_dat); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", word_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] lit[$];
    int st;
    bit ok;
`ifdef UART_HEX_CRLF_EN
    lit = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
`else
    lit = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h20};
`endif
    clear_sb();
    push_word(16'h1A2F, st);
    word_valid = 1'b0;
    wait_rx(NB, ok);
    checks++;
    if (!ok || rx_q.size() != lit.size()) begin
      errors++;
      $display("FAIL single_count: got %0d bytes required %0d", rx_q.size(), lit.size());
    end
    for (int i = 0; i < lit.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== lit[i]) begin
        errors++;
        $display("FAIL single_byte%0d: got %h required %h", i, rx_q[i], lit[i]);
      end
    end
    checks++;
    if (wr_cyc_q.size() == 0 || wr_cyc_q[0] - acc_cyc != 2) begin
      errors++;
      $display("FAIL latency: got %0d required 2", (wr_cyc_q.size() == 0) ? -1 : wr_cyc_q[0] - acc_cyc);
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL single_wr_busy: got %0d required 0", viol); end
  endtask

  task automatic test_back_to_back();
    int st;
    int stall_tot;
    bit ok;
    clear_sb();
    stall_tot = 0;
    for (int i = 0; i < 10; i++) begin
      push_word(16'(i * 4099 + 7), st);
      stall_tot += st;
    end
    word_valid = 1'b0;
    checks++; if (max_level != 8) begin errors++; $display("FAIL b2b_max_level: got %0d required 8", max_level); end
    checks++; if (stall_tot == 0) begin errors++; $display("FAIL b2b_held: got %0d stalls required >0", stall_tot); end
    wait_rx(10 * NB, ok);
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL b2b_ready: got %0d bad cycles required 0", ready_bad); end
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] a, e;
      a = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_byte: got %h required %h", a, e); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL b2b_wr_busy: got %0d required 0", viol); end
  endtask

  task automatic test_zero_ffff();
    int st;
    bit ok;
    clear_sb();
    push_word(16'h0000, st);
    push_word(16'hFFFF, st);
    word_valid = 1'b0;
    wait_rx(2 * NB, ok);
    checks++;
    if (!ok || rx_q.size() != 2 * NB) begin
      errors++;
      $display("FAIL zf_count: got %0d required %0d", rx_q.size(), 2 * NB);
    end
    checks++;
    if (rx_q.size() > NB && (rx_q[0] !== 8'h30 || rx_q[NB] !== 8'h46)) begin
      errors++;
      $display("FAIL zf_first_digits: got %h/%h required 30/46", rx_q[0], rx_q[NB]);
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] a, e;
      a = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL zf_byte: got %h required %h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    int st;
    int k;
    bit ok;
    clear_sb();
    push_word(16'hABCD, st);
    push_word(16'h1234, st);
    push_word(16'h5678, st);
    push_word(16'h9ABC, st);
    word_valid = 1'b0;
    k = 0;
    while (rx_q.size() < 2 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (rx_q.size() < 2) begin errors++; $display("FAIL rm_timeout: got %0d bytes required 2", rx_q.size()); end
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL rm_level_before: got %0d required 3", fifo_level); end
    checks++;
    if (rx_q.size() >= 2 && (rx_q[0] !== 8'h41 || rx_q[1] !== 8'h42)) begin
      errors++;
      $display("FAIL rm_digits: got %h %h required 41 42", rx_q[0], rx_q[1]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL rm_wr: got %b required 0", uart_wr); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rm_level: got %0d required 0", fifo_level); end
    rst = 1'b0;
    clear_sb();
    repeat (200) begin
      @(posedge clk); #1;
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rm_quiet: got %0d bytes required 0", rx_q.size()); end
    push_word(16'h0F0F, st);
    word_valid = 1'b0;
    wait_rx(NB, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rm_after_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] a, e;
      a = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL rm_after_byte: got %h required %h", a, e); end
    end
  endtask

  task automatic test_level();
    int st;
    int k;
    bit ok;
    clear_sb();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL lvl_start: got %0d required 0", fifo_level); end
    word_valid = 1'b1;
    word_dat   = 16'h1234;
    @(posedge clk); #1;
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL lvl_push: got %0d required 1", fifo_level); end
    word_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL lvl_pop: got %0d required 0", fifo_level); end
    for (int i = 0; i < 8; i++) push_word(16'hC000 + 16'(i), st);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL lvl_full: got %0d required 8", fifo_level); end
    word_valid = 1'b1;
    word_dat   = 16'hDEAD;
    k = 0;
    while (fifo_level == 4'd8 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL lvl_full_pop: got %0d required 7", fifo_level); end
    @(posedge clk); #1;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL lvl_refill: got %0d required 8", fifo_level); end
    word_valid = 1'b0;
    wait_rx(10 * NB, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lvl_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] a, e;
      a = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL lvl_byte: got %h required %h", a, e); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL lvl_wr_busy: got %0d required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_ffff();
    test_reset_mid();
    test_level();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
